// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone pipelined round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    // Watchdog limit used when the top level does not override TIMEOUT_CYCLES.
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Widest request vector the round-robin search supports.
    localparam int RR_MAX = 8;

    // Returns the first requester found searching upward from last+1
    // (modulo n), or -1 when no request is pending.
    function automatic int rr_next(input logic [RR_MAX-1:0] req, input int last, input int n);
        int pick;
        int idx;
        pick = -1;
        for (int i = 1; i <= RR_MAX; i++) begin
            idx = last + i;
            if (idx >= n) idx = idx - n;
            if ((pick < 0) && (i <= n) && req[idx[2:0]]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_p_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: request vector plus last
// grant in, next owner index plus valid out.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [RR_MAX-1:0] w_req;
    int                w_res;

    // Widen the request vector and run the shared search.
    always_comb begin
        w_req   = RR_MAX'(i_req);
        w_res   = rr_next(w_req, int'(i_last), N);
        o_valid = (w_res >= 0);
        o_idx   = IDX_W'(w_res);
    end

endmodule

// File: rtl/wb_p_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 pipelined slave port between
// NUM_MASTERS masters. The bus is owned per cyc assertion; outstanding
// requests are counted so responses only reach the owner.
// Optional response watchdog: define WB_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; slave side quiet; pick next requester
// GRANTED | r_grant owns the slave port until it drops its cyc
module wb_p_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int GRANULARITY     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]                 m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]                 m_dat_i,
    input  logic [NUM_MASTERS-1:0]                            m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/GRANULARITY)-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]                            m_stb_i,
    input  logic [NUM_MASTERS-1:0]                            m_cyc_i,
    output logic [DATA_WIDTH-1:0]                             m_dat_o,
    output logic [NUM_MASTERS-1:0]                            m_ack_o,
    output logic [NUM_MASTERS-1:0]                            m_err_o,
    output logic [NUM_MASTERS-1:0]                            m_stall_o,
    output logic [ADDR_WIDTH-1:0]                             s_adr_o,
    output logic [DATA_WIDTH-1:0]                             s_dat_o,
    output logic                                              s_we_o,
    output logic [DATA_WIDTH/GRANULARITY-1:0]                 s_sel_o,
    output logic                                              s_stb_o,
    output logic                                              s_cyc_o,
    input  logic [DATA_WIDTH-1:0]                             s_dat_i,
    input  logic                                              s_ack_i,
    input  logic                                              s_err_i,
    input  logic                                              s_stall_i
);

    localparam int SEL_W = DATA_WIDTH / GRANULARITY;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_last_grant_nxt;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] w_outstanding_nxt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_owner_cyc;
    logic             w_limit;
    logic             w_inc;
    logic             w_dec;
    logic             w_timeout;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_req   (m_cyc_i),
        .i_last  (r_last_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_owner_cyc = (r_state == GRANTED) && m_cyc_i[r_grant];
    assign w_limit     = (r_outstanding == CNT_MAX);
    assign w_inc       = s_stb_o & ~s_stall_i;
    assign w_dec       = s_ack_i | s_err_i;

    // Request fields always follow the current grant index; s_cyc_o/s_stb_o qualify them.
    assign s_adr_o = m_adr_i[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_dat_o = m_dat_i[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign s_sel_o = m_sel_i[int'(r_grant)*SEL_W +: SEL_W];
    assign s_we_o  = m_we_i[r_grant];
    assign m_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_run;

    assign w_wd_run  = (r_outstanding != '0) && !w_dec;
    assign w_timeout = w_owner_cyc && w_wd_run && (r_wd_cnt == '0);

    // Watchdog down-counter: reloads while nothing is pending or the slave answers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wd_cnt <= WD_RELOAD;
        end else if (!w_wd_run || w_timeout) begin
            r_wd_cnt <= WD_RELOAD;
        end else begin
            r_wd_cnt <= r_wd_cnt - 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State, grant and outstanding-count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_last_grant  <= LAST_RST;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_outstanding <= w_outstanding_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, release when the owner drops cyc.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = w_pick_idx;
                end
            end
            GRANTED: begin
                if (!m_cyc_i[r_grant]) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outstanding count: cleared on release or watchdog abort, saturates at 0.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (!w_owner_cyc || w_timeout) begin
            w_outstanding_nxt = '0;
        end else if (w_inc && !w_dec) begin
            w_outstanding_nxt = r_outstanding + 1'b1;
        end else if (!w_inc && w_dec && (r_outstanding != '0)) begin
            w_outstanding_nxt = r_outstanding - 1'b1;
        end
    end

    // Slave-side qualifiers and per-master responses; non-owners always see stall.
    always_comb begin
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        if (r_state == GRANTED) begin
            s_cyc_o            = m_cyc_i[r_grant] & ~w_timeout;
            s_stb_o            = m_cyc_i[r_grant] & m_stb_i[r_grant] & ~w_limit & ~w_timeout;
            m_stall_o[r_grant] = s_stall_i | w_limit | w_timeout;
            m_ack_o[r_grant]   = s_ack_i;
            m_err_o[r_grant]   = s_err_i | w_timeout;
        end
    end

endmodule

// File: tb/tb_wb_p_arbiter.sv
// Self-checking bench for wb_p_arbiter (2 masters, 4 outstanding, watchdog 8).
module tb_wb_p_arbiter;

    typedef struct {
        int          m;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] m_adr_i;
    logic [63:0] m_dat_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_sel_i;
    logic [1:0]  m_stb_i;
    logic [1:0]  m_cyc_i;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_err_o;
    logic [1:0]  m_stall_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic        s_stb_o;
    logic        s_cyc_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_err_i;
    logic        s_stall_i;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_n    = 0;
    int   acc_cnt  = 0;
    int   ack_cnt [2] = '{0, 0};
    bit   ack_en   = 1'b1;
    exp_t sb [$];

    wb_p_arbiter #(
        .NUM_MASTERS     (2),
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .GRANULARITY     (8),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_stb_i   (m_stb_i),
        .m_cyc_i   (m_cyc_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_stall_o (m_stall_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_stall_i (s_stall_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] base_adr(input int m);
        return {8'(m), 24'h000100};
    endfunction

    // Slave model: accepted requests push the expected owner (address top byte)
    // and read data; the slave acks one cycle later when ack_en is set.
    initial begin : slave_model
        bit          acc;
        logic [31:0] a;
        exp_t        e;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(negedge clk);
            acc = (s_cyc_o === 1'b1) && (s_stb_o === 1'b1) && (s_stall_i === 1'b0);
            a   = s_adr_o;
            if (acc) begin
                acc_cnt++;
                e.m   = int'(a[31:24]);
                e.dat = rdata(a);
                sb.push_back(e);
            end
            @(posedge clk); #1;
            if (acc && ack_en) begin
                s_ack_i = 1'b1;
                s_dat_i = rdata(a);
            end else begin
                s_ack_i = 1'b0;
                s_dat_i = '0;
            end
        end
    end

    // Scoreboard: every routed ack must match the oldest accepted request.
    initial begin : ack_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_i === 1'b0) begin
                for (int m = 0; m < 2; m++) begin
                    if (m_ack_o[m] === 1'b1) begin
                        n_checks++;
                        ack_cnt[m]++;
                        if (sb.size() == 0) begin
                            $display("FAIL sb_unexpected_ack: master %0d got ack, expected none", m);
                        end else begin
                            e = sb.pop_front();
                            if (e.m != m || m_dat_o !== e.dat)
                                $display("FAIL sb_ack_route: got master %0d data %h, expected master %0d data %h",
                                         m, m_dat_o, e.m, e.dat);
                            else
                                n_pass++;
                        end
                    end
                end
            end
        end
    end

    initial begin : sim_limit
        #400000;
        $display("FAIL sim_limit: simulation did not finish within the time limit");
        $fatal(1, "time limit reached");
    end

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
        m_cyc_i[m]           = cyc;
        m_stb_i[m]           = stb;
        m_adr_i[m*32 +: 32]  = adr;
        m_dat_i[m*32 +: 32]  = ~adr;
        m_we_i[m]            = 1'b0;
        m_sel_i[m*4 +: 4]    = 4'hF;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // Pipelined master: n reads, then waits for n acks and drops cyc for one cycle.
    task automatic do_burst(input int m, input int n, output int t_assert, output int t_start, output int t_drop);
        int          issued;
        int          a0;
        int          budget;
        logic [31:0] base;
        base     = base_adr(m);
        t_assert = cyc_n;
        t_start  = -1;
        issued   = 0;
        a0       = ack_cnt[m];
        budget   = 200;
        set_m(m, 1'b1, 1'b1, base);
        while (issued < n && budget > 0) begin
            @(negedge clk);
            if (m_stall_o[m] === 1'b0) begin
                if (issued == 0) t_start = cyc_n;
                issued++;
            end
            @(posedge clk); #1;
            budget--;
            if (issued < n) set_m(m, 1'b1, 1'b1, base + 32'(issued * 4));
            else            set_m(m, 1'b1, 1'b0, base);
        end
        while ((ack_cnt[m] - a0) < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            $display("FAIL burst_budget_m%0d: issued %0d acks %0d, required %0d each", m, issued, ack_cnt[m] - a0, n);
        end
        t_drop = cyc_n;
        set_m(m, 1'b0, 1'b0, base);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i     = 1'b1;
        m_adr_i   = '0;
        m_dat_i   = '0;
        m_we_i    = '0;
        m_sel_i   = '0;
        m_stb_i   = '0;
        m_cyc_i   = '0;
        s_stall_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++; if (s_cyc_o !== 1'b0)    $display("FAIL reset_s_cyc: got %b want 0", s_cyc_o);       else n_pass++;
        n_checks++; if (s_stb_o !== 1'b0)    $display("FAIL reset_s_stb: got %b want 0", s_stb_o);       else n_pass++;
        n_checks++; if (m_ack_o !== 2'b00)   $display("FAIL reset_m_ack: got %b want 00", m_ack_o);      else n_pass++;
        n_checks++; if (m_err_o !== 2'b00)   $display("FAIL reset_m_err: got %b want 00", m_err_o);      else n_pass++;
        n_checks++; if (m_stall_o !== 2'b11) $display("FAIL reset_m_stall: got %b want 11", m_stall_o);  else n_pass++;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_master();
        int ta, ts, td, a0, bad;
        a0  = ack_cnt[0];
        bad = 0;
        fork
            do_burst(0, 3, ta, ts, td);
            begin
                repeat (8) begin
                    @(negedge clk);
                    if (m_stall_o[1] !== 1'b1) bad++;
                end
            end
        join
        n_checks++; if (ts != ta + 1)          $display("FAIL single_latency: first accept cycle %0d want %0d", ts, ta + 1); else n_pass++;
        n_checks++; if (ack_cnt[0] - a0 != 3)  $display("FAIL single_acks: got %0d want 3", ack_cnt[0] - a0);             else n_pass++;
        n_checks++; if (bad != 0)              $display("FAIL single_m1_stall: %0d cycles with stall low, want 0", bad);   else n_pass++;
    endtask

    task automatic test_both_same_cycle();
        int ta0, ts0, td0, ta1, ts1, td1;
        apply_reset();
        fork
            do_burst(0, 2, ta0, ts0, td0);
            do_burst(1, 2, ta1, ts1, td1);
        join
        n_checks++; if (ts0 != ta0 + 1) $display("FAIL both_m0_first: m0 start %0d want %0d", ts0, ta0 + 1); else n_pass++;
        n_checks++; if (ts1 != td0 + 2) $display("FAIL both_m1_after_idle: m1 start %0d want %0d", ts1, td0 + 2); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL both_sb_empty: %0d entries left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_round_robin();
        int ta, ts, td;
        int a1a, s1a, d1a, a1b, s1b, d1b, a0, s0, d0;
        do_burst(0, 1, ta, ts, td);
        fork
            begin
                do_burst(1, 2, a1a, s1a, d1a);
                do_burst(1, 2, a1b, s1b, d1b);
            end
            do_burst(0, 2, a0, s0, d0);
        join
        n_checks++; if (s1a != a1a + 1) $display("FAIL rr_first_m1: start %0d want %0d", s1a, a1a + 1); else n_pass++;
        n_checks++; if (s0 != d1a + 2)  $display("FAIL rr_second_m0: start %0d want %0d", s0, d1a + 2); else n_pass++;
        n_checks++; if (s1b != d0 + 2)  $display("FAIL rr_third_m1: start %0d want %0d", s1b, d0 + 2); else n_pass++;
    endtask

    task automatic test_outstanding_limit();
        int acc0;
        ack_en = 1'b0;
        acc0   = acc_cnt;
        set_m(0, 1'b1, 1'b1, base_adr(0));
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                n_checks++;
                if (m_stall_o[0] !== (k >= 5))
                    $display("FAIL limit_stall_req%0d: got %b want %b", k, m_stall_o[0], (k >= 5));
                else
                    n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (s_stb_o !== 1'b0) $display("FAIL limit_s_stb: got %b want 0", s_stb_o); else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (acc_cnt - acc0 != 4) $display("FAIL limit_accepted: got %0d want 4", acc_cnt - acc0); else n_pass++;
        set_m(0, 1'b0, 1'b0, base_adr(0));
        @(posedge clk); #1;
        sb.delete();
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_transfer();
        int acc0;
        ack_en = 1'b0;
        acc0   = acc_cnt;
        set_m(0, 1'b1, 1'b1, base_adr(0));
        repeat (3) begin @(posedge clk); #1; end
        set_m(0, 1'b1, 1'b0, base_adr(0));
        set_m(1, 1'b1, 1'b0, base_adr(1));
        n_checks++; if (acc_cnt - acc0 != 2) $display("FAIL rstmid_setup: accepted %0d want 2", acc_cnt - acc0); else n_pass++;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++; if (s_cyc_o !== 1'b0)    $display("FAIL rstmid_s_cyc: got %b want 0", s_cyc_o);     else n_pass++;
        n_checks++; if (m_stall_o !== 2'b11) $display("FAIL rstmid_stall: got %b want 11", m_stall_o);  else n_pass++;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (m_stall_o !== 2'b10)      $display("FAIL rstmid_m0_wins: stall %b want 10", m_stall_o);            else n_pass++;
        n_checks++; if (s_adr_o !== base_adr(0))  $display("FAIL rstmid_adr: got %h want %h", s_adr_o, base_adr(0));       else n_pass++;
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, base_adr(0));
        set_m(1, 1'b0, 1'b0, base_adr(1));
        @(posedge clk); #1;
        sb.delete();
        ack_en = 1'b1;
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c0, pulses, t_pulse, budget, bad;
        logic [1:0] err_at;
        logic       cyc_at;
        ack_en  = 1'b0;
        c0      = -1;
        pulses  = 0;
        t_pulse = -1;
        err_at  = '0;
        cyc_at  = 1'b1;
        budget  = 10;
        set_m(0, 1'b1, 1'b1, base_adr(0));
        while (c0 < 0 && budget > 0) begin
            @(negedge clk);
            if (s_stb_o === 1'b1 && m_stall_o[0] === 1'b0) c0 = cyc_n;
            @(posedge clk); #1;
            budget--;
        end
        set_m(0, 1'b1, 1'b0, base_adr(0));
        repeat (16) begin
            @(negedge clk);
            if (m_err_o !== 2'b00) begin
                pulses++;
                t_pulse = cyc_n;
                err_at  = m_err_o;
                cyc_at  = s_cyc_o;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (pulses != 1)       $display("FAIL timeout_pulses: got %0d want 1", pulses);               else n_pass++;
        n_checks++; if (t_pulse != c0 + 8) $display("FAIL timeout_cycle: got %0d want %0d", t_pulse, c0 + 8);     else n_pass++;
        n_checks++; if (err_at !== 2'b01)  $display("FAIL timeout_err_vec: got %b want 01", err_at);              else n_pass++;
        n_checks++; if (cyc_at !== 1'b0)   $display("FAIL timeout_s_cyc: got %b want 0", cyc_at);                 else n_pass++;
        bad = 0;
        set_m(0, 1'b1, 1'b1, base_adr(0));
        repeat (4) begin
            @(negedge clk);
            if (m_stall_o[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad != 0) $display("FAIL timeout_cleared: %0d stalled requests want 0", bad); else n_pass++;
        set_m(0, 1'b0, 1'b0, base_adr(0));
        @(posedge clk); #1;
        sb.delete();
        ack_en = 1'b1;
    endtask
`else
    task automatic test_timeout();
        int errs, drops;
        ack_en = 1'b0;
        errs   = 0;
        drops  = 0;
        set_m(0, 1'b1, 1'b1, base_adr(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_m(0, 1'b1, 1'b0, base_adr(0));
        repeat (20) begin
            @(negedge clk);
            if (m_err_o !== 2'b00) errs++;
            if (s_cyc_o !== 1'b1) drops++;
            @(posedge clk); #1;
        end
        n_checks++; if (errs != 0)  $display("FAIL hang_no_err: %0d err cycles want 0", errs);   else n_pass++;
        n_checks++; if (drops != 0) $display("FAIL hang_bus_held: %0d cyc-low cycles want 0", drops); else n_pass++;
        set_m(0, 1'b0, 1'b0, base_adr(0));
        @(posedge clk); #1;
        sb.delete();
        ack_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_master();
        test_both_same_cycle();
        test_round_robin();
        test_outstanding_limit();
        test_reset_mid_transfer();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
